// File: rtl/seq_blinker_if.sv
// Playback-stage bus: controller handshake, sequence-memory read port and LED drive.
interface seq_blinker_if;
    logic       start;
    logic [3:0] level;
    logic       mem_rd_en;
    logic [3:0] mem_addr;
    logic [1:0] mem_rdata;
    logic [3:0] led;
    logic       busy;
    logic       done;

    // Blinker side: drives memory reads, LEDs and status.
    modport master (
        input  start, level, mem_rdata,
        output mem_rd_en, mem_addr, led, busy, done
    );

    // Controller/memory side.
    modport slave (
        output start, level, mem_rdata,
        input  mem_rd_en, mem_addr, led, busy, done
    );
endinterface

// File: rtl/seq_blinker.sv
// Simon playback stage: reads colour codes 0..lvl-1 and flashes each on a one-hot LED bus.
module seq_blinker #(
    parameter int unsigned MAX_LEVEL  = 10,
    parameter int unsigned ON_CYCLES  = 25000000,
    parameter int unsigned OFF_CYCLES = 12500000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic          clk,
    input  logic          reset,
    seq_blinker_if.master bus
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned LED_W = 4;
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
    localparam logic [IDX_W-1:0] LVL_MAX  = IDX_W'(MAX_LEVEL);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_ON,
        ST_OFF,
        ST_DONE
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [IDX_W-1:0]   lvl, lvl_n;
    logic [1:0]         colour, colour_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   lvl_req;

    logic               rd_en_q, rd_en_n;
    logic [IDX_W-1:0]   addr_q, addr_n;
    logic [LED_W-1:0]   led_q, led_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;

    // Next-state logic; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        lvl_n    = lvl;
        colour_n = colour;
        cnt_n    = cnt;
        lvl_req  = (bus.level > LVL_MAX) ? LVL_MAX : bus.level;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    lvl_n   = lvl_req;
                    idx_n   = '0;
                    state_n = (lvl_req == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: state_n = ST_WAIT;
            ST_WAIT: begin
                colour_n = bus.mem_rdata;
                cnt_n    = '0;
                state_n  = ST_ON;
            end
            ST_ON: begin
                if (cnt == ON_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_OFF;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_OFF: begin
                if (cnt == OFF_LAST) begin
                    cnt_n = '0;
                    if (idx == lvl - IDX_W'(1)) begin
                        state_n = ST_DONE;
                    end else begin
                        idx_n   = idx + IDX_W'(1);
                        state_n = ST_FETCH;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        rd_en_n = (state_n == ST_FETCH);
        addr_n  = rd_en_n ? idx_n : addr_q;
        led_n   = (state_n == ST_ON) ? (LED_W'(1) << colour_n) : '0;
        busy_n  = (state_n != ST_IDLE);
        done_n  = (state_n == ST_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            lvl     <= '0;
            colour  <= '0;
            cnt     <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            lvl     <= lvl_n;
            colour  <= colour_n;
            cnt     <= cnt_n;
            rd_en_q <= rd_en_n;
            addr_q  <= addr_n;
            led_q   <= led_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.led       = led_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_blinker.sv
// Bench for seq_blinker: directed scenarios plus random playbacks against a cycle-indexed model.
module tb_seq_blinker;

    localparam int MAXL = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_v;
    logic [3:0] level_v;
    logic       sel;
    logic [1:0] mem [16];
    logic [1:0] rdata_a, rdata_b;

    int n_assert = 0;
    int n_fail   = 0;

    seq_blinker_if bus_a ();
    seq_blinker_if bus_b ();

    seq_blinker #(.MAX_LEVEL(10), .ON_CYCLES(3), .OFF_CYCLES(2), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    seq_blinker #(.MAX_LEVEL(10), .ON_CYCLES(1), .OFF_CYCLES(1), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    always #5 clk = ~clk;

    assign bus_a.start     = start_v & ~sel;
    assign bus_b.start     = start_v & sel;
    assign bus_a.level     = level_v;
    assign bus_b.level     = level_v;
    assign bus_a.mem_rdata = rdata_a;
    assign bus_b.mem_rdata = rdata_b;

    // Registered-read sequence memories, shared contents.
    always @(posedge clk) begin
        if (bus_a.mem_rd_en) rdata_a <= mem[bus_a.mem_addr];
        if (bus_b.mem_rd_en) rdata_b <= mem[bus_b.mem_addr];
    end

    logic [3:0] o_led, o_addr;
    logic       o_rd, o_busy, o_done;
    assign o_led  = sel ? bus_b.led       : bus_a.led;
    assign o_addr = sel ? bus_b.mem_addr  : bus_a.mem_addr;
    assign o_rd   = sel ? bus_b.mem_rd_en : bus_a.mem_rd_en;
    assign o_busy = sel ? bus_b.busy      : bus_a.busy;
    assign o_done = sel ? bus_b.done      : bus_a.done;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs k cycles after the start-sampling edge, from step arithmetic.
    task automatic expect_at(input int k, input int lvl, input int on_c, input int off_c,
                             output logic [3:0] e_led, output logic e_rd,
                             output logic [3:0] e_addr, output logic e_busy,
                             output logic e_done);
        int p, end_k, s, o;
        p      = 2 + on_c + off_c;
        end_k  = lvl * p + 1;
        e_led  = 4'd0;
        e_rd   = 1'b0;
        e_addr = 4'd0;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (k < end_k) begin
            e_busy = 1'b1;
            s = (k - 1) / p;
            o = (k - 1) % p;
            if (o == 0) begin
                e_rd   = 1'b1;
                e_addr = 4'(s);
            end
            if (o >= 2 && o < 2 + on_c) e_led = 4'(1 << mem[s]);
        end else if (k == end_k) begin
            e_busy = 1'b1;
            e_done = 1'b1;
        end
    endtask

    // One playback from the current negedge; checks every cycle through one idle cycle.
    task automatic run(input int l_req, input bit hold, input int chg_at,
                       input logic [3:0] chg_val, input int stop_k);
        int lvl, on_c, off_c, last;
        logic [3:0] e_led, e_addr;
        logic e_rd, e_busy, e_done;
        lvl   = (l_req > MAXL) ? MAXL : l_req;
        on_c  = sel ? 1 : 3;
        off_c = sel ? 1 : 2;
        last  = lvl * (2 + on_c + off_c) + 2;
        start_v = 1'b1;
        level_v = 4'(l_req);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            expect_at(k, lvl, on_c, off_c, e_led, e_rd, e_addr, e_busy, e_done);
            chk($sformatf("led L=%0d k=%0d", l_req, k), 8'(o_led), 8'(e_led));
            chk($sformatf("rd_en L=%0d k=%0d", l_req, k), 8'(o_rd), 8'(e_rd));
            chk($sformatf("busy L=%0d k=%0d", l_req, k), 8'(o_busy), 8'(e_busy));
            chk($sformatf("done L=%0d k=%0d", l_req, k), 8'(o_done), 8'(e_done));
            if (e_rd) chk($sformatf("addr L=%0d k=%0d", l_req, k), 8'(o_addr), 8'(e_addr));
            if (!hold && k == 1) start_v = 1'b0;
            if (k == chg_at) level_v = chg_val;
            if (k == stop_k) break;
        end
    endtask

    initial begin
        sel     = 1'b0;
        start_v = 1'b0;
        level_v = 4'd0;
        reset   = 1'b1;
        rdata_a = 2'd0;
        rdata_b = 2'd0;
        for (int i = 0; i < 16; i++) mem[i] = 2'd0;
        repeat (3) @(negedge clk);

        chk("reset led_a", 8'(bus_a.led), 8'd0);
        chk("reset busy_a", 8'(bus_a.busy), 8'd0);
        chk("reset done_a", 8'(bus_a.done), 8'd0);
        chk("reset rd_a", 8'(bus_a.mem_rd_en), 8'd0);
        chk("reset addr_a", 8'(bus_a.mem_addr), 8'd0);
        chk("reset led_b", 8'(bus_b.led), 8'd0);
        chk("reset busy_b", 8'(bus_b.busy), 8'd0);
        reset = 1'b0;
        @(negedge clk);

        // Three-step playback, start pulsed for one cycle.
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
        run(3, 1'b0, 0, 4'd0, 0);

        // Zero level: immediate done, no reads.
        run(0, 1'b0, 0, 4'd0, 0);

        // Level above MAX_LEVEL clamps to 10.
        for (int i = 0; i < 16; i++) mem[i] = 2'd1;
        run(13, 1'b0, 0, 4'd0, 0);

        // start held, level changed mid-run; a second playback follows DONE.
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1; mem[4] = 2'd2;
        run(3, 1'b1, 8, 4'd5, 0);
        run(5, 1'b0, 0, 4'd0, 0);

        // Reset during the second ON phase aborts the playback.
        run(3, 1'b0, 0, 4'd0, 10);
        reset = 1'b1;
        @(negedge clk);
        chk("mid reset led", 8'(o_led), 8'd0);
        chk("mid reset busy", 8'(o_busy), 8'd0);
        chk("mid reset done", 8'(o_done), 8'd0);
        chk("mid reset rd_en", 8'(o_rd), 8'd0);
        chk("mid reset addr", 8'(o_addr), 8'd0);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("post reset done k=%0d", k), 8'(o_done), 8'd0);
            chk($sformatf("post reset busy k=%0d", k), 8'(o_busy), 8'd0);
        end
        run(3, 1'b0, 0, 4'd0, 0);

        // Random playbacks on the fast-cadence instance.
        sel = 1'b1;
        @(negedge clk);
        for (int it = 0; it < 20; it++) begin
            for (int a = 0; a < 16; a++) mem[a] = 2'($urandom_range(0, 3));
            run(int'($urandom_range(1, 10)), 1'b0, 0, 4'd0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_blinker.md
Name: seq_blinker

Overview:
Playback stage for the Simon game. It sits between the sequence memory and the game controller. When the controller asserts on_blinker, this block reads colour codes 0..level-1 from the sequence memory and flashes each one on a one-hot LED bus with a fixed on/off cadence. It then pulses blinker_done, which moves the controller into acceptInput.

Parameters:
MAX_LEVEL, 10, largest playable sequence length; a larger requested level is clamped to this.
ON_CYCLES, 25000000, clock cycles each LED stays lit (0.5 s at 50 MHz); must be >= 1.
OFF_CYCLES, 12500000, dark gap in clock cycles after each flash; must be >= 1.
CNT_W, 25, width of the on/off cycle counter; must hold max(ON_CYCLES, OFF_CYCLES).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  on_blinker from the controller; level-sensitive, sampled only in IDLE
level  in  4  number of steps to play (controller out_level)
mem_rd_en  out  1  sequence-memory read strobe
mem_addr  out  4  sequence-memory read address (step index)
mem_rdata  in  2  colour code; valid the cycle after mem_rd_en (registered-read RAM)
led  out  4  one-hot LED drive: code 0->led[0] green, 1->led[1] red, 2->led[2] yellow, 3->led[3] blue
busy  out  1  high in every state except IDLE
done  out  1  blinker_done; one-cycle pulse

Behaviour:
- Reset (synchronous, takes priority in any state, including mid-flash):
  - State goes to IDLE; step index, counter and latched colour clear to 0.
  - led=0, done=0, busy=0, mem_rd_en=0, mem_addr=0.
- States: IDLE, FETCH, WAIT, ON, OFF, DONE. All outputs decode from registered state only, so there are no combinational paths from inputs to outputs.
- IDLE, start=1 at the clock edge:
  - Latch lvl = min(level, MAX_LEVEL) and set idx=0.
  - If lvl=0, go to DONE; no memory read is issued.
  - Otherwise go to FETCH.
- IDLE, start=0: stay in IDLE.
- FETCH: mem_rd_en=1, mem_addr=idx. Next state WAIT.
- WAIT: mem_rd_en=0. At the edge, latch colour=mem_rdata, clear cnt, go to ON.
- ON:
  - led = one-hot(colour); cnt increments each cycle.
  - At cnt=ON_CYCLES-1, clear cnt and go to OFF.
  - LED is lit for exactly ON_CYCLES cycles.
- OFF:
  - led=0 for exactly OFF_CYCLES cycles.
  - At the end, if idx=lvl-1 go to DONE; otherwise idx<=idx+1 and go to FETCH.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE.
- Timing:
  - Cycles per step = 2 + ON_CYCLES + OFF_CYCLES.
  - done appears lvl*(2+ON_CYCLES+OFF_CYCLES)+1 cycles after the start-sampling edge (1 cycle for lvl=0).
- start while busy is ignored; level changes while busy are ignored (value latched at start).
- start still high in IDLE after DONE starts a new playback. The controller must drop on_blinker by the cycle after done.
- led is never multi-hot and is 0 outside ON.
- mem_addr holds its last value outside FETCH.
- idx never exceeds lvl-1; the 4-bit idx never wraps because MAX_LEVEL <= 15.

Test Plan:
- ON=3, OFF=2, memory {0:2,1:0,2:3}, level=3, start pulsed 1 cycle:
  - Reads at addr 0, 1, 2, each exactly once.
  - led sequence 0100 x3, 0000 x2, 0001 x3, 0000 x2, 1000 x3, 0000 x2.
  - done high for 1 cycle at cycle 22 after the start edge.
- level=0, start=1 -> no mem_rd_en; done high at cycle 1 only; led stays 0.
- level=13 with MAX_LEVEL=10, memory all 1 -> exactly 10 flashes of led=0010, addresses 0..9; done after 10*(2+ON+OFF)+1 cycles.
- start held high for the whole playback and level changed 3->5 mid-run -> playback stays 3 steps; exactly one done pulse; a second playback begins the cycle after DONE if start is still 1.
- reset asserted during the second ON phase -> next cycle led=0, busy=0, done=0; no done pulse follows; a fresh start replays from addr 0.
- Random levels 1-10 with random memory contents (ON=1, OFF=1) -> scoreboard matches led codes and addresses in order, and done timing equals lvl*4+1.
